pipeline_ctrl: RTL

Parametrised central pipeline controller for the 5-stage core: it supersedes the stand-alone load-use hazard unit by combining load-use interlock, EX-stage operand forwarding, taken-branch flush and data-memory wait freeze. It also carries saturating stall and flush performance counters. The controller keeps its own shadow pipeline of valid/destination state for the EX, MEM and WB stages. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write and flush enables plus the ALU-input forwarding muxes.

---
 rtl/pipeline_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage hazard control with load-use interlock, forwarding, branch flush, memory freeze and perf counters.
module pipeline_ctrl #(
  parameter int REG_AW   = 4,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_in,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              valid_id,
  output logic              valid_ex,
  output logic              valid_mem,
  output logic              valid_wb,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [REG_AW-1:0] ex_rd, ex_rs, ex_rt, mem_rd, wb_rd;
  logic              ex_rw, ex_mr, mem_rw, wb_rw;
  logic              freeze, flush, load_use, hazard;
  function automatic logic nz(input logic [REG_AW-1:0] r);
    return !(ZERO_REG && r == '0);
  endfunction
  function automatic logic [1:0] fsel(input logic [REG_AW-1:0] r);
    return (valid_mem && mem_rw && mem_rd == r && nz(r)) ? 2'b10 :
           (valid_wb && wb_rw && wb_rd == r && nz(r)) ? 2'b01 : 2'b00;
  endfunction
  assign freeze   = mem_busy;
  assign flush    = !freeze && valid_ex && ex_branch_taken;
  assign hazard   = nz(ex_rd) && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  assign load_use = !freeze && !flush && valid_id && valid_ex && ex_mr && ex_rw && hazard;
  always_comb begin
    pc_write    = !freeze && !load_use;
    ifid_write  = !freeze && !flush && !load_use;
    idex_bubble = load_use;
    ifid_flush  = flush;
    idex_flush  = flush;
    fwd_a       = valid_ex ? fsel(ex_rs) : 2'b00;
    fwd_b       = valid_ex ? fsel(ex_rt) : 2'b00;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {valid_id, valid_ex, valid_mem, valid_wb} <= '0;
      {ex_rd, ex_rs, ex_rt, mem_rd, wb_rd}      <= '0;
      {ex_rw, ex_mr, mem_rw, wb_rw}             <= '0;
    end else if (!freeze) begin
      valid_wb  <= valid_mem;
      wb_rd     <= mem_rd;
      wb_rw     <= mem_rw;
      valid_mem <= valid_ex;
      mem_rd    <= ex_rd;
      mem_rw    <= ex_rw;
      valid_ex  <= valid_id && !flush && !load_use;
      ex_rd     <= id_rd;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rw     <= id_reg_write;
      ex_mr     <= id_mem_read;
      valid_id  <= flush ? 1'b0 : load_use ? valid_id : if_valid_in;
    end
  end
  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze || load_use) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
